fmul_iter: RTL and testbench

//  Multi-cycle IEEE-754 single-precision multiplier. It is the multiply counterpart
//  of the iterative radix-4 divider and uses the same operand/result/flag format.

---
 rtl/fmul_iter.sv | 168 ++++++++++++++++
 tb/tb_fmul_iter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fmul_iter.sv
// Iterative IEEE-754 single-precision multiplier: radix-4 Booth, 13 accumulate steps,
// RNE rounding, subnormals flushed, fixed 15-cycle latency for every operand class.
module fmul_iter #(
  parameter logic [31:0] DEFAULT_NAN = 32'hffc00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        valid,
  output logic [31:0] rslt,
  output logic [4:0]  flag
);

  typedef enum logic [1:0] {S_IDLE, S_BOOTH, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_step;
  logic        r_busy, r_valid;
  logic [31:0] r_x, r_y, r_rslt;
  logic [4:0]  r_flag;
  logic [26:0] r_m;
  logic [49:0] r_acc;

  logic        w_xzero, w_yzero, w_xinf, w_yinf, w_xnan, w_ynan, w_sgn;
  logic [23:0] w_mx, w_in_my;
  logic [49:0] w_mx1, w_mx2, w_pp, w_acc_next;
  logic [47:0] w_p;
  logic [9:0]  w_e0, w_e1;
  logic signed [9:0] w_e2;
  logic [22:0] w_mant0, w_mant;
  logic        w_g, w_s, w_rnd, w_nx;
  logic [31:0] w_rslt;
  logic [4:0]  w_flag;

  assign w_xzero = ~|r_x[30:23];
  assign w_yzero = ~|r_y[30:23];
  assign w_xinf  = (&r_x[30:23]) & ~|r_x[22:0];
  assign w_yinf  = (&r_y[30:23]) & ~|r_y[22:0];
  assign w_xnan  = (&r_x[30:23]) & |r_x[22:0];
  assign w_ynan  = (&r_y[30:23]) & |r_y[22:0];
  assign w_sgn   = r_x[31] ^ r_y[31];

  assign w_mx    = w_xzero ? '0 : {1'b1, r_x[22:0]};
  assign w_in_my = (~|y[30:23]) ? '0 : {1'b1, y[22:0]};

  assign w_mx1 = {2'b00, w_mx, 24'd0};
  assign w_mx2 = {1'b0, w_mx, 25'd0};

  always_comb begin
    w_pp = '0;
    case (r_m[2:0])
      3'b001, 3'b010: w_pp = w_mx1;
      3'b011:         w_pp = w_mx2;
      3'b100:         w_pp = -w_mx2;
      3'b101, 3'b110: w_pp = -w_mx1;
      default:        w_pp = '0;
    endcase
  end

  // Shift precedes the add so that after 13 digits the accumulator holds P unscaled
  // and exact: every discarded low bit is zero.
  assign w_acc_next = {{2{r_acc[49]}}, r_acc[49:2]} + w_pp;

  assign w_p  = r_acc[47:0];
  assign w_e0 = {2'b00, r_x[30:23]} + {2'b00, r_y[30:23]} - 10'd127;

  always_comb begin
    if (w_p[47]) begin
      w_mant0 = w_p[46:24];
      w_g     = w_p[23];
      w_s     = |w_p[22:0];
      w_e1    = w_e0 + 10'd1;
    end else begin
      w_mant0 = w_p[45:23];
      w_g     = w_p[22];
      w_s     = |w_p[21:0];
      w_e1    = w_e0;
    end
  end

  assign w_rnd = w_g & (w_s | w_mant0[0]);
  assign w_nx  = w_g | w_s;
  assign {w_e2, w_mant} = {w_e1, w_mant0} + {32'd0, w_rnd};

  always_comb begin
    w_rslt = {w_sgn, w_e2[7:0], w_mant};
    w_flag = {4'b0000, w_nx};
    if (w_e2 >= 10'sd255) begin
      w_rslt = {w_sgn, 8'hff, 23'd0};
      w_flag = 5'b00101;
    end else if (w_e2 <= 10'sd0) begin
      w_rslt = {w_sgn, 31'd0};
      w_flag = 5'b00011;
    end
    if (w_xnan) begin
      w_rslt = r_x | 32'h00400000;
      w_flag = {~r_x[22] | (w_ynan & ~r_y[22]), 4'b0000};
    end else if (w_ynan) begin
      w_rslt = r_y | 32'h00400000;
      w_flag = {~r_y[22], 4'b0000};
    end else if ((w_xinf & w_yzero) | (w_xzero & w_yinf)) begin
      w_rslt = DEFAULT_NAN;
      w_flag = 5'b10000;
    end else if (w_xinf | w_yinf) begin
      w_rslt = {w_sgn, 8'hff, 23'd0};
      w_flag = '0;
    end else if (w_xzero | w_yzero) begin
      w_rslt = {w_sgn, 31'd0};
      w_flag = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_rslt  <= '0;
      r_flag  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_x     <= x;
            r_y     <= y;
            r_m     <= {2'b00, w_in_my, 1'b0};
            r_acc   <= '0;
            r_step  <= 4'd1;
            r_busy  <= 1'b1;
            r_state <= S_BOOTH;
          end
        end
        S_BOOTH: begin
          r_acc  <= w_acc_next;
          r_m    <= r_m >> 2;
          r_step <= r_step + 4'd1;
          if (r_step == 4'd13) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_rslt  <= w_rslt;
          r_flag  <= w_flag;
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign rslt  = r_rslt;
  assign flag  = r_flag;

endmodule

// File: tb/tb_fmul_iter.sv
// Directed bench for fmul_iter: hand-computed products, specials, latency,
// back-to-back spacing and asynchronous abort.
module tb_fmul_iter;

  logic        clk = 1'b0;
  logic        reset_n, req, busy, valid;
  logic [31:0] x, y, rslt;
  logic [4:0]  flag;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fmul_iter #(.DEFAULT_NAN(32'hffc00000)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .x(x), .y(y),
    .busy(busy), .valid(valid), .rslt(rslt), .flag(flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [4:0] ef);
    int unsigned n;
    @(negedge clk);
    x = a; y = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0; x = ~a; y = ~b;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/lat"}, n, 32'd15);
    chk({tag, "/rslt"}, rslt, er);
    chk({tag, "/flag"}, 32'(flag), 32'(ef));
    @(negedge clk);
    chk({tag, "/vwidth"}, 32'(valid), 32'd0);
    chk({tag, "/idle"}, 32'(busy), 32'd0);
    chk({tag, "/hold"}, rslt, er);
  endtask

  initial begin
    int unsigned n, nv;
    reset_n = 1'b0; req = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/valid", 32'(valid), 32'd0);
    chk("rst/rslt", rslt, 32'd0);
    chk("rst/flag", 32'(flag), 32'd0);
    reset_n = 1'b1;

    run_op("mul3",    32'h3fc00000, 32'h40000000, 32'h40400000, 5'b00000);
    run_op("nx",      32'h3f800001, 32'h3f800001, 32'h3f800002, 5'b00001);
    run_op("rndup",   32'h3fc00001, 32'h3fc00001, 32'h40100002, 5'b00001);
    run_op("tieup",   32'h3f800001, 32'h3fc00000, 32'h3fc00002, 5'b00001);
    run_op("tiedn",   32'h3f800003, 32'h3fc00000, 32'h3fc00004, 5'b00001);
    run_op("p47",     32'h3fffffff, 32'h3fffffff, 32'h407ffffe, 5'b00001);
    run_op("neg",     32'hbfc00000, 32'h40000000, 32'hc0400000, 5'b00000);
    run_op("ovf",     32'h7f7fffff, 32'h40000000, 32'h7f800000, 5'b00101);
    run_op("unf",     32'h00800000, 32'h3f000000, 32'h00000000, 5'b00011);
    run_op("unfneg",  32'h80800000, 32'h00800000, 32'h80000000, 5'b00011);
    run_op("infzero", 32'h7f800000, 32'h80000000, 32'hffc00000, 5'b10000);
    run_op("xsnan",   32'h7f800001, 32'h3f800000, 32'h7fc00001, 5'b10000);
    run_op("ninf",    32'hff800000, 32'h40000000, 32'hff800000, 5'b00000);
    run_op("ysnan",   32'h3f800000, 32'hff800001, 32'hffc00001, 5'b10000);
    run_op("xq_ys",   32'h7fc00000, 32'h7f800001, 32'h7fc00000, 5'b10000);
    run_op("xqnan",   32'h7fc00123, 32'h3f800000, 32'h7fc00123, 5'b00000);
    run_op("inf_qn",  32'h7f800000, 32'h7fc00000, 32'h7fc00000, 5'b00000);
    run_op("zero",    32'h80000000, 32'h40000000, 32'h80000000, 5'b00000);
    run_op("daz",     32'h00000001, 32'h40000000, 32'h00000000, 5'b00000);
    run_op("dazinf",  32'h00000001, 32'hff800000, 32'hffc00000, 5'b10000);

    // req held high; operands other than those present at idle must be ignored
    @(negedge clk);
    x = 32'h3fc00000; y = 32'h40000000; req = 1'b1;
    @(negedge clk);
    x = 32'h3f800001; y = 32'h3f800001;
    chk("b2b/busy", 32'(busy), 32'd1);
    n = 1;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b/lat1", n, 32'd15);
    chk("b2b/rslt1", rslt, 32'h40400000);
    @(negedge clk);
    chk("b2b/width", 32'(valid), 32'd0);
    chk("b2b/idle", 32'(busy), 32'd0);
    x = 32'h7f7fffff; y = 32'h40000000;
    @(negedge clk);
    x = 32'h3f800001; y = 32'h3f800001;
    n = 1;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b/gap", n + 1, 32'd16);
    chk("b2b/rslt2", rslt, 32'h7f800000);
    chk("b2b/flag2", 32'(flag), 32'h05);
    req = 1'b0;
    @(negedge clk);
    chk("b2b/width2", 32'(valid), 32'd0);

    // asynchronous abort at cnt=7
    @(negedge clk);
    x = 32'h3fc00000; y = 32'h40000000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort/busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/valid", 32'(valid), 32'd0);
    chk("abort/rslt", rslt, 32'd0);
    chk("abort/flag", 32'(flag), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort/novalid", nv, 32'd0);
    run_op("post", 32'h3f800001, 32'h3f800001, 32'h3f800002, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
